// File: rtl/cic_dec_ctrl.sv
// Sequencing controller for the decimating CIC filter: gates ADC strobes, flushes and settles
// the filter, buffers decimated samples for a valid/ready consumer and flags lost/missing outputs.
module cic_dec_ctrl #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned DECIM          = 400,
  parameter int unsigned SETTLE_OUTPUTS = 3,
  parameter int unsigned FLUSH_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  cic_reset,
  output logic                  cic_clk_enable,
  output logic [DATA_WIDTH-1:0] cic_data,
  input  logic                  cic_ce_out,
  input  logic [DATA_WIDTH-1:0] cic_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  running,
  output logic                  overrun,
  output logic                  wdog_err,
  input  logic                  err_clr
);

  localparam int unsigned WD_LIMIT = 2 * DECIM;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
  localparam int unsigned FL_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned SO_W     = (SETTLE_OUTPUTS > 1) ? $clog2(SETTLE_OUTPUTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [SO_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  cic_reset_q, cic_reset_d;
  logic                  cic_ce_q, cic_ce_d;
  logic [DATA_WIDTH-1:0] cic_data_q, cic_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  running_q, running_d;
  logic                  overrun_q, overrun_d;
  logic                  wdog_q, wdog_d;

  logic fwd_c, wd_fire_c, load_c, pop_c, ovr_set_c;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      wd_cnt_q     <= '0;
      cic_reset_q  <= 1'b1;
      cic_ce_q     <= 1'b0;
      cic_data_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      running_q    <= 1'b0;
      overrun_q    <= 1'b0;
      wdog_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      cic_reset_q  <= cic_reset_d;
      cic_ce_q     <= cic_ce_d;
      cic_data_q   <= cic_data_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      running_q    <= running_d;
      overrun_q    <= overrun_d;
      wdog_q       <= wdog_d;
    end
  end

  // Next-state, counters, data paths and flags
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = '0;
    settle_cnt_d = '0;
    wd_cnt_d     = wd_cnt_q;
    cic_ce_d     = 1'b0;
    cic_data_d   = cic_data_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    ovr_set_c    = 1'b0;

    fwd_c     = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    wd_fire_c = fwd_c && (wd_cnt_q == WD_W'(WD_LIMIT));
    load_c    = (state_q == ST_RUN) && cic_ce_out;
    pop_c     = m_valid_q && m_ready;

    // Dropping enable overrides everything, so counters always restart from zero
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FLUSH;
        ST_FLUSH: begin
          if (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1)) state_d = ST_SETTLE;
          else                                        flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
        ST_SETTLE: begin
          if (wd_fire_c) begin
            state_d = ST_FLUSH;
          end else if (cic_ce_out) begin
            if (settle_cnt_q == SO_W'(SETTLE_OUTPUTS - 1)) state_d = ST_RUN;
            else                                           settle_cnt_d = settle_cnt_q + SO_W'(1);
          end else begin
            settle_cnt_d = settle_cnt_q;
          end
        end
        ST_RUN:  if (wd_fire_c) state_d = ST_FLUSH;
        default: state_d = ST_IDLE;
      endcase
    end

    // Strobes since the last filter output; saturates at the limit
    if (cic_ce_out || ((state_d == ST_SETTLE) && (state_q != ST_SETTLE))) begin
      wd_cnt_d = '0;
    end else if (fwd_c && adc_valid && (wd_cnt_q != WD_W'(WD_LIMIT))) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    if (fwd_c && adc_valid) begin
      cic_ce_d   = 1'b1;
      cic_data_d = adc_data;
    end

    // One-entry output buffer; a load into a full, unpopped buffer is dropped
    if (!enable) begin
      m_valid_d = 1'b0;
    end else if (load_c && (!m_valid_q || pop_c)) begin
      m_valid_d = 1'b1;
      m_data_d  = cic_dout;
    end else begin
      if (load_c) ovr_set_c = 1'b1;
      if (pop_c)  m_valid_d = 1'b0;
    end

    overrun_d   = (overrun_q && !err_clr) || ovr_set_c;
    wdog_d      = (wdog_q && !err_clr) || wd_fire_c;
    cic_reset_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    running_d   = (state_d == ST_RUN);
  end

  assign cic_reset      = cic_reset_q;
  assign cic_clk_enable = cic_ce_q;
  assign cic_data       = cic_data_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign running        = running_q;
  assign overrun        = overrun_q;
  assign wdog_err       = wdog_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: directed sequences, a backpressure vector table and an
// output scoreboard that pops expected samples on each consumer handshake.
module tb_cic_dec_ctrl;

  localparam int unsigned DW = 12;

  logic          clk, reset_n, enable, adc_valid, cic_ce_out, m_ready, err_clr;
  logic [DW-1:0] adc_data, cic_dout;
  logic          cic_reset, cic_clk_enable, m_valid, running, overrun, wdog_err;
  logic [DW-1:0] cic_data, m_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q[$];

  typedef struct {
    logic          ce;
    logic [DW-1:0] dout;
    logic          rdy;
    logic          clr;
    logic          push;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_ovr;
  } vec_t;

  vec_t tbl[8];

  cic_dec_ctrl #(.DATA_WIDTH(DW), .DECIM(400), .SETTLE_OUTPUTS(3), .FLUSH_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_valid(adc_valid), .adc_data(adc_data),
    .cic_reset(cic_reset), .cic_clk_enable(cic_clk_enable), .cic_data(cic_data),
    .cic_ce_out(cic_ce_out), .cic_dout(cic_dout), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .running(running), .overrun(overrun), .wdog_err(wdog_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ce_pulse(input logic [DW-1:0] d);
    cic_ce_out = 1'b1;
    cic_dout   = d;
    step();
    cic_ce_out = 1'b0;
  endtask

  task automatic wait_reset_low(input string nm);
    int n = 0;
    while (cic_reset && n < 20) begin
      step();
      n++;
    end
    chk(nm, 32'(cic_reset), 32'd0);
  endtask

  // Scoreboard: compare each accepted sample against the oldest expected one
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", m_data);
      end else begin
        chk("sb_data", 32'(m_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    tbl[0] = '{1'b1, 12'h111, 1'b0, 1'b0, 1'b1, 1'b1, 12'h111, 1'b0};
    tbl[1] = '{1'b1, 12'h222, 1'b0, 1'b0, 1'b0, 1'b1, 12'h111, 1'b1};
    tbl[2] = '{1'b1, 12'h333, 1'b1, 1'b0, 1'b1, 1'b1, 12'h333, 1'b1};
    tbl[3] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h333, 1'b1};
    tbl[4] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h333, 1'b0};
    tbl[5] = '{1'b1, 12'h444, 1'b0, 1'b0, 1'b1, 1'b1, 12'h444, 1'b0};
    tbl[6] = '{1'b1, 12'h555, 1'b0, 1'b1, 1'b0, 1'b1, 12'h444, 1'b1};
    tbl[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h444, 1'b0};

    reset_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    cic_ce_out = 1'b0; cic_dout = '0; m_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_cic_reset", 32'(cic_reset), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_clk_en", 32'(cic_clk_enable), 32'd0);
    chk("rst_flags", 32'({overrun, wdog_err}), 32'd0);
    chk("rst_cic_data", 32'(cic_data), 32'd0);

    reset_n = 1'b1;
    step();
    adc_valid = 1'b1; adc_data = 12'h5A5;
    step();
    adc_valid = 1'b0;
    chk("idle_no_enable", 32'(cic_clk_enable), 32'd0);

    // Start-up: cic_reset held through exactly four flush clocks
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("flush_hold_%0d", i), 32'(cic_reset), 32'd1);
    end
    step();
    chk("flush_release", 32'(cic_reset), 32'd0);
    chk("settle_not_running", 32'(running), 32'd0);

    // Settle outputs are discarded
    for (int i = 0; i < 3; i++) begin
      ce_pulse(12'h0F0 + 12'(i));
      chk($sformatf("settle_m_valid_%0d", i), 32'(m_valid), 32'd0);
    end
    chk("run_entered", 32'(running), 32'd1);

    sb_q.push_back(12'h7A5);
    ce_pulse(12'h7A5);
    chk("first_m_valid", 32'(m_valid), 32'd1);
    chk("first_m_data", 32'(m_data), 32'h7A5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("first_popped", 32'(m_valid), 32'd0);

    // Input gating in RUN
    adc_valid = 1'b1; adc_data = 12'h801;
    step();
    adc_valid = 1'b0; adc_data = 12'h3C3;
    chk("run_cic_data", 32'(cic_data), 32'h801);
    chk("run_clk_en", 32'(cic_clk_enable), 32'd1);
    step();
    chk("clk_en_pulse", 32'(cic_clk_enable), 32'd0);
    chk("cic_data_hold", 32'(cic_data), 32'h801);

    // Backpressure, overrun and flag-clear table
    for (int i = 0; i < 8; i++) begin
      cic_ce_out = tbl[i].ce; cic_dout = tbl[i].dout;
      m_ready = tbl[i].rdy;   err_clr = tbl[i].clr;
      if (tbl[i].push) sb_q.push_back(tbl[i].dout);
      step();
      chk($sformatf("bp%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].exp_v));
      chk($sformatf("bp%0d_m_data", i), 32'(m_data), 32'(tbl[i].exp_d));
      chk($sformatf("bp%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
    end
    cic_ce_out = 1'b0; m_ready = 1'b0; err_clr = 1'b0;

    // Watchdog: 2*DECIM strobes with no filter output
    adc_valid = 1'b1;
    for (int i = 0; i < 799; i++) step();
    chk("wdog_below_limit", 32'(wdog_err), 32'd0);
    step();
    adc_valid = 1'b0;
    for (int n = 0; n < 4 && !wdog_err; n++) step();
    chk("wdog_fired", 32'(wdog_err), 32'd1);
    chk("wdog_flush", 32'(cic_reset), 32'd1);
    chk("wdog_not_running", 32'(running), 32'd0);
    wait_reset_low("wdog_resettle");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wdog_cleared", 32'(wdog_err), 32'd0);

    // Set event coincident with err_clr keeps the flag
    adc_valid = 1'b1;
    for (int i = 0; i < 800; i++) step();
    adc_valid = 1'b0;
    err_clr = 1'b1;
    for (int n = 0; n < 4 && !wdog_err; n++) step();
    err_clr = 1'b0;
    chk("wdog_set_wins", 32'(wdog_err), 32'd1);

    // Abort from RUN with a full buffer
    wait_reset_low("abort_resettle");
    for (int i = 0; i < 3; i++) ce_pulse(12'h010);
    chk("abort_run", 32'(running), 32'd1);
    ce_pulse(12'h6C3);
    chk("abort_full", 32'(m_valid), 32'd1);
    chk("abort_full_data", 32'(m_data), 32'h6C3);
    enable = 1'b0;
    step();
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_cic_reset", 32'(cic_reset), 32'd1);
    chk("abort_running", 32'(running), 32'd0);

    // Asynchronous reset mid-SETTLE, then wait for enable
    enable = 1'b1;
    step();
    wait_reset_low("rst_mid_settle_reach");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_cic_reset", 32'(cic_reset), 32'd1);
    chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rst_waits_enable", 32'(cic_reset), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
